// File: rtl/cpu2core_pio_pkg.sv
// Shared constants, bus payload type and edge-select helper for the CPU-to-core PIO receiver.
package cpu2core_pio_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_DATA    = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_DIR     = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGECAP = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  // One Avalon slave access as seen in a single cycle.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } pio_bus_t;

  // Pick which transitions count as an event for the configured edge type.
  function automatic logic [DATA_W-1:0] edge_sel(input logic [DATA_W-1:0] rise,
                                                 input logic [DATA_W-1:0] fall,
                                                 input int unsigned       edge_type);
    logic [DATA_W-1:0] sel;
    sel = rise | fall;
    if (edge_type == EDGE_RISE) sel = rise;
    else if (edge_type == EDGE_FALL) sel = fall;
    return sel;
  endfunction

endpackage

// File: rtl/cpu2core_sync_bits.sv
// Multi-bit, multi-stage async-reset synchroniser for the PIO input lines.
module cpu2core_sync_bits #(
  parameter int unsigned WIDTH       = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_stage;

  // Shift the raw input through the flop chain; stage 0 is the metastable catcher.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stage <= '0;
    end else begin
      r_stage <= {r_stage[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/cpu2core_pio_rx.sv
// Receive side of the CPU-to-core PIO link: synchronised input, sticky edge capture,
// Avalon-MM register file and level IRQ.
// Config macro CPU2CORE_PIO_RX_BITCLR_EN: when defined, EDGECAP writes clear only the
// bits written as 1; when undefined, any EDGECAP write clears every captured bit.
module cpu2core_pio_rx
  import cpu2core_pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);

  pio_bus_t         w_bus;
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr_mask;
  logic             w_wr_cap;
  logic             w_unused_wdata;

  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;

  assign w_bus = '{we: chipselect & ~write_n, addr: address, data: writedata};

  cpu2core_sync_bits #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (in_port),
    .o_q     (w_sync)
  );

  // Transitions between the previous and current synchronised samples.
  assign w_rise = w_sync & ~r_prev;
  assign w_fall = ~w_sync & r_prev;
  assign w_edge = WIDTH'(edge_sel(DATA_W'(w_rise), DATA_W'(w_fall), EDGE_TYPE));

  // Upper writedata bits have no storage behind them.
  assign w_wdata        = WIDTH'(w_bus.data);
  assign w_unused_wdata = ^w_bus.data;

  assign w_wr_mask = w_bus.we && (w_bus.addr == ADDR_IRQMASK);
  assign w_wr_cap  = w_bus.we && (w_bus.addr == ADDR_EDGECAP);

`ifdef CPU2CORE_PIO_RX_BITCLR_EN
  assign w_clr = w_wr_cap ? w_wdata : '0;
`else
  assign w_clr = w_wr_cap ? {WIDTH{1'b1}} : '0;
`endif

  // Previous-sample register feeding the edge detector.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= '0;
    end else begin
      r_prev <= w_sync;
    end
  end

  // IRQ mask register, fully software writable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '0;
    end else if (w_wr_mask) begin
      r_mask <= w_wdata;
    end
  end

  // Sticky edge flags; a new edge beats a simultaneous clear of the same bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cap <= '0;
    end else begin
      r_cap <= (r_cap & ~w_clr) | w_edge;
    end
  end

  // Zero-wait-state read mux, zero-extended to the bus width.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata = DATA_W'(w_sync);
      ADDR_DIR:     readdata = '0;
      ADDR_IRQMASK: readdata = DATA_W'(r_mask);
      ADDR_EDGECAP: readdata = DATA_W'(r_cap);
      default:      readdata = '0;
    endcase
  end

  // Level interrupt straight from the registers, so reset drops it asynchronously.
  assign irq = |(r_cap & r_mask);

endmodule

// File: tb/tb_cpu2core_pio_rx.sv
// Self-checking bench for cpu2core_pio_rx: three instances (rising, falling, any edge)
// share one bus and input, and are compared against a sample-history reference model.
module tb_cpu2core_pio_rx;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [1:0]  in_port;
  logic [31:0] rd [3];
  logic [2:0]  irqv;

  int n_total = 0;
  int n_bad   = 0;

`ifdef CPU2CORE_PIO_RX_BITCLR_EN
  localparam bit BITCLR = 1'b1;
`else
  localparam bit BITCLR = 1'b0;
`endif

  always #5 clk = ~clk;

  cpu2core_pio_rx #(.WIDTH(2), .SYNC_STAGES(S), .EDGE_TYPE(0)) dut_r (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd[0]), .in_port(in_port),
    .irq(irqv[0]));

  cpu2core_pio_rx #(.WIDTH(2), .SYNC_STAGES(S), .EDGE_TYPE(1)) dut_f (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd[1]), .in_port(in_port),
    .irq(irqv[1]));

  cpu2core_pio_rx #(.WIDTH(2), .SYNC_STAGES(S), .EDGE_TYPE(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd[2]), .in_port(in_port),
    .irq(irqv[2]));

  // Reference model: hist[j] is in_port sampled j+1 clocks ago; DATA shows the sample
  // S clocks old, and an edge is flagged one clock after it reaches DATA.
  logic [1:0] hist [0:S];
  logic [1:0] m_cap [3];
  logic [1:0] m_mask;

  function automatic logic [1:0] m_event(input int t);
    logic [1:0] now_v, old_v;
    now_v = hist[S-1];
    old_v = hist[S];
    if (t == 0) return now_v & ~old_v;
    if (t == 1) return ~now_v & old_v;
    return now_v ^ old_v;
  endfunction

  function automatic logic [1:0] m_clear();
    if (!(chipselect && !write_n && address == 2'd3)) return 2'b00;
    if (BITCLR) return writedata[1:0];
    return 2'b11;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j <= S; j++) hist[j] <= 2'b00;
      for (int t = 0; t < 3; t++) m_cap[t] <= 2'b00;
      m_mask <= 2'b00;
    end else begin
      for (int t = 0; t < 3; t++) m_cap[t] <= (m_cap[t] & ~m_clear()) | m_event(t);
      if (chipselect && !write_n && address == 2'd2) m_mask <= writedata[1:0];
      hist[0] <= in_port;
      for (int j = 1; j <= S; j++) hist[j] <= hist[j-1];
    end
  end

  function automatic logic [31:0] exp_read(input logic [1:0] a, input int t);
    case (a)
      2'd0:    return {30'd0, hist[S-1]};
      2'd2:    return {30'd0, m_mask};
      2'd3:    return {30'd0, m_cap[t]};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic exp_irq(input int t);
    return |(m_cap[t] & m_mask);
  endfunction

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_at(input logic [1:0] a, input int t, output logic [31:0] v);
    address = a;
    #1;
    v = rd[t];
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset_n = 1'b0; in_port = 2'b00; address = 2'd0;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    repeat (3) @(negedge clk);
    rd_at(2'd0, 0, v);
    n_total++;
    if (v !== 32'd0) begin n_bad++; $display("FAIL rst_data_in_reset got=%h want=0", v); end
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      rd_at(2'(a), 0, v);
      n_total++;
      if (v !== 32'd0) begin n_bad++; $display("FAIL rst_read addr=%0d got=%h want=0", a, v); end
    end
    n_total++;
    if (irqv !== 3'b000) begin n_bad++; $display("FAIL rst_irq got=%b want=000", irqv); end
  endtask

  task automatic test_edge_basic();
    logic [31:0] v;
    @(negedge clk) in_port = 2'b01;
    @(negedge clk);
    rd_at(2'd0, 0, v);
    n_total++;
    if (v !== 32'd0) begin n_bad++; $display("FAIL data_1clk got=%h want=0", v); end
    @(negedge clk);
    rd_at(2'd0, 0, v);
    n_total++;
    if (v !== 32'd1) begin n_bad++; $display("FAIL data_2clk got=%h want=1", v); end
    rd_at(2'd3, 0, v);
    n_total++;
    if (v !== 32'd0) begin n_bad++; $display("FAIL cap_2clk got=%h want=0", v); end
    @(negedge clk);
    rd_at(2'd3, 0, v);
    n_total++;
    if (v !== 32'd1) begin n_bad++; $display("FAIL cap_3clk got=%h want=1", v); end
    n_total++;
    if (irqv[0] !== 1'b0) begin n_bad++; $display("FAIL irq_masked got=%b want=0", irqv[0]); end
    wr(2'd2, 32'hFFFF_FFFD);
    #1;
    rd_at(2'd2, 0, v);
    n_total++;
    if (v !== 32'd1) begin n_bad++; $display("FAIL mask_upper_ignored got=%h want=1", v); end
    n_total++;
    if (irqv !== 3'b101) begin n_bad++; $display("FAIL irq_after_mask got=%b want=101", irqv); end
  endtask

  task automatic test_bitclr();
    logic [31:0] v;
    logic [31:0] want;
    @(negedge clk) in_port = 2'b11;
    repeat (4) @(negedge clk);
    wr(2'd2, 32'd3);
    rd_at(2'd3, 0, v);
    n_total++;
    if (v !== 32'd3) begin n_bad++; $display("FAIL cap_both got=%h want=3", v); end
    wr(2'd3, 32'd1);
    want = BITCLR ? 32'd2 : 32'd0;
    rd_at(2'd3, 0, v);
    n_total++;
    if (v !== want) begin n_bad++; $display("FAIL cap_after_clr got=%h want=%h", v, want); end
    n_total++;
    if (irqv[0] !== BITCLR) begin
      n_bad++; $display("FAIL irq_after_clr got=%b want=%b", irqv[0], BITCLR);
    end
  endtask

  task automatic test_collision();
    logic [31:0] v;
    @(negedge clk) in_port = 2'b00;
    repeat (5) @(negedge clk);
    wr(2'd3, 32'hFFFF_FFFF);
    rd_at(2'd3, 0, v);
    n_total++;
    if (v !== 32'd0) begin n_bad++; $display("FAIL coll_precleared got=%h want=0", v); end
    in_port = 2'b01;
    @(negedge clk);
    @(negedge clk);
    address = 2'd3; writedata = 32'd1; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    rd_at(2'd3, 0, v);
    n_total++;
    if (v !== 32'd1) begin n_bad++; $display("FAIL edge_beats_clear got=%h want=1", v); end
  endtask

  task automatic test_edge_types();
    logic [31:0] v;
    @(negedge clk) in_port = 2'b00;
    repeat (5) @(negedge clk);
    wr(2'd3, 32'hFFFF_FFFF);
    for (int t = 0; t < 3; t++) begin
      rd_at(2'd3, t, v);
      n_total++;
      if (v !== 32'd0) begin n_bad++; $display("FAIL types_clear inst=%0d got=%h want=0", t, v); end
    end
    in_port = 2'b10;
    repeat (5) @(negedge clk);
    rd_at(2'd3, 1, v);
    n_total++;
    if (v !== 32'd0) begin n_bad++; $display("FAIL fall_on_rise got=%h want=0", v); end
    rd_at(2'd3, 2, v);
    n_total++;
    if (v !== 32'd2) begin n_bad++; $display("FAIL any_on_rise got=%h want=2", v); end
    wr(2'd3, 32'hFFFF_FFFF);
    in_port = 2'b00;
    repeat (5) @(negedge clk);
    rd_at(2'd3, 0, v);
    n_total++;
    if (v !== 32'd0) begin n_bad++; $display("FAIL rise_on_fall got=%h want=0", v); end
    rd_at(2'd3, 1, v);
    n_total++;
    if (v !== 32'd2) begin n_bad++; $display("FAIL fall_on_fall got=%h want=2", v); end
    rd_at(2'd3, 2, v);
    n_total++;
    if (v !== 32'd2) begin n_bad++; $display("FAIL any_on_fall got=%h want=2", v); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) in_port = 2'($urandom);
      address    = 2'($urandom);
      writedata  = $urandom;
      chipselect = 1'($urandom);
      write_n    = ($urandom_range(0, 3) != 0);
      #1;
      for (int t = 0; t < 3; t++) begin
        n_total++;
        if (rd[t] !== exp_read(address, t) || irqv[t] !== exp_irq(t)) begin
          n_bad++;
          $display("FAIL rand it=%0d inst=%0d addr=%0d rd=%h irq=%b want rd=%h irq=%b",
                   i, t, address, rd[t], irqv[t], exp_read(address, t), exp_irq(t));
        end
      end
    end
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    wr(2'd2, 32'd3);
    in_port = 2'b00;
    repeat (5) @(negedge clk);
    wr(2'd3, 32'hFFFF_FFFF);
    in_port = 2'b01;
    repeat (4) @(negedge clk);
    #1;
    n_total++;
    if (irqv !== 3'b101) begin n_bad++; $display("FAIL irq_before_reset got=%b want=101", irqv); end
    #2 reset_n = 1'b0;
    #1;
    n_total++;
    if (irqv !== 3'b000) begin n_bad++; $display("FAIL irq_async_drop got=%b want=000", irqv); end
    in_port = 2'b10;
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rd_at(2'd0, 0, v);
    n_total++;
    if (v !== 32'd2) begin n_bad++; $display("FAIL rel_data got=%h want=2", v); end
    rd_at(2'd3, 0, v);
    n_total++;
    if (v !== 32'd0) begin n_bad++; $display("FAIL rel_cap_early got=%h want=0", v); end
    @(negedge clk);
    rd_at(2'd3, 0, v);
    n_total++;
    if (v !== 32'd2) begin n_bad++; $display("FAIL rel_cap got=%h want=2", v); end
    rd_at(2'd3, 1, v);
    n_total++;
    if (v !== 32'd0) begin n_bad++; $display("FAIL rel_cap_fall got=%h want=0", v); end
    rd_at(2'd2, 0, v);
    n_total++;
    if (v !== 32'd0 || irqv !== 3'b000) begin
      n_bad++; $display("FAIL rel_mask_irq mask=%h irq=%b want mask=0 irq=000", v, irqv);
    end
  endtask

  initial begin
    test_reset();
    test_edge_basic();
    test_bitclr();
    test_collision();
    test_edge_types();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
